sp_core: RTL and testbench
==========================

# sp_core

Single-cycle execution core for the simple processor project. It accepts one instruction per cycle on an `in_valid`/`inst` stream and executes it against a 32×32 register file and a word-addressed data memory. It drives `inst_addr` with the address of the next instruction it expects, so the instruction source sits on the other end of this interface. It is the instance checked by the processor pattern bench; register file `r[0:31]` and data memory `mem[0:MEM_DEPTH-1]` are hierarchically visible.

## Interface
- `MEM_DEPTH`, 4096: data memory depth in 32-bit words.
- `MEM_AW`, 12: data memory address width, log2(MEM_DEPTH).
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `inst` is valid this cycle and must be executed.
- `inst` input 32: instruction word. Don't-care (may be X) when `in_valid`=0.
- `out_valid` output 1: the previous cycle's instruction has retired; `r`, `mem` and `inst_addr` reflect it.
- `inst_addr` output 32: byte address of the next instruction to fetch.

## Operation
- Decode fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], func=[5:0], imm=[15:0].
- Immediate extension:
  - andi (1), ori (2): zero-extend.
  - All other I-type opcodes: sign-extend.
- R-type (op=0), writes `r[rd]`:
  - func 0 and; 1 or; 2 add; 3 sub.
  - func 4 slt: signed compare, result 1/0.
  - func 5 sll: `r[rs] << shamt` (rt ignored).
  - func ≥6 nor.
- I-type:
  - 1 andi, 2 ori, 3 addi, 4 subi: write `r[rt]` = `r[rs]` op imm.
  - 5 lw: `r[rt]` = `mem[r[rs]+sext(imm)]`.
  - 6 sw: `mem[r[rs]+sext(imm)]` = `r[rt]`.
  - 7 beq, 8 bne: no register write.
  - 9 lui: `r[rt]` = {imm, 16'h0}.
  - Any other op: no-op.
- Memory address: low `MEM_AW` bits of the 32-bit sum; higher bits ignored (wrap). Memory read is combinational; memory write happens on the clock edge.
- `r[0]` is an ordinary writable register (no hardwired zero).
- All arithmetic is 32-bit two's complement; overflow wraps; no flags.
- Next PC:
  - beq taken when `r[rs]==r[rt]`; bne taken when `r[rs]!=r[rt]`.
  - Taken: `inst_addr + 4 + (sext(imm)<<2)`.
  - Otherwise: `inst_addr + 4`.
  - Operand values are those before this instruction's writeback.
- With `in_valid`=0: no register, memory or PC change.

## Timing
- Reset (async assert):
  - `out_valid`=0, `inst_addr`=0, all `r`=0.
  - `mem` is not reset; it keeps preloaded contents.
- Latency is 1 cycle. Edge k sees `in_valid`=1 and commits the writeback, memory write and new `inst_addr`. `out_valid`=1 after edge k and stays high until the next edge.
- `out_valid` is a registered copy of `in_valid`. Back-to-back instructions give continuous `out_valid`=1. When `in_valid` drops, `out_valid` falls one cycle later.
- `inst_addr` is stable for a full cycle before the next `in_valid`. The source fetches `inst` from `inst_addr` sampled after the prior edge; no stall or bubble is ever needed.
- Dependent instructions back-to-back need no forwarding logic: the register file is read combinationally from committed state.
- Reset asserted mid-stream: the in-flight instruction is discarded and the PC restarts at 0. Memory writes already committed persist.
- First `out_valid` occurs at most 1 cycle after the first `in_valid` (bench limit: 10).

## Test plan
- Reset: pulse `rst_n` low with `clk` held → `out_valid`=0, `inst_addr`=0, all `r`=0.
- ALU chain:
  - Stimulus: `addi r1,r0,-3`; `ori r2,r0,0xFFFF`; `slt r3,r1,r2`; `sll r4,r2,4`; `nor r5,r1,r2`; `lui r6,0x8001`.
  - Expected: r1=0xFFFFFFFD, r2=0x0000FFFF, r3=1, r4=0x000FFFF0, r5=0x00000000, r6=0x80010000.
  - `out_valid` high every cycle after the first.
- Memory:
  - Stimulus: `addi r1,r0,100`; `sw r1,4(r1)`; `lw r7,104(r0)`.
  - Expected: mem[104]=100, r7=100.
  - Stimulus: `lw r8,-1(r0)`.
  - Expected: r8=mem[4095] (wrap).
- Branches:
  - Stimulus: r1=r2=5, `beq r1,r2,+3` at addr 8.
  - Expected: next `inst_addr`=24.
  - Stimulus: `bne r1,r2,-2` at addr 24.
  - Expected: `inst_addr`=28.
  - Stimulus: a backward taken bne at 40 with imm=-3.
  - Expected: `inst_addr`=32.
- Gap in stream: `in_valid` low for 2 cycles mid-program → `out_valid` low exactly those 2 cycles (delayed by 1); `r`/`inst_addr` unchanged.
- Mid-run reset: assert `rst_n` after 5 instructions → `inst_addr`=0, `r` cleared, prior `sw` values retained in `mem`.

Source files
------------

// File: rtl/sp_core_if.sv
// sp_core_if: instruction stream between an instruction source and sp_core.
// Latency: none; pure wiring bundle.
// Backpressure: none; the core accepts an instruction on every cycle that in_valid is high.
interface sp_core_if;
  logic        in_valid;
  logic [31:0] inst;
  logic        out_valid;
  logic [31:0] inst_addr;

  // Instruction source side: drives instructions, observes retire and fetch address
  modport master (
    output in_valid,
    output inst,
    input  out_valid,
    input  inst_addr
  );

  // Core side: consumes instructions, reports retire and next fetch address
  modport slave (
    input  in_valid,
    input  inst,
    output out_valid,
    output inst_addr
  );
endinterface

// File: rtl/sp_core.sv
// sp_core: single-cycle execution core, 32x32 register file plus word-addressed data memory.
// Latency: 1 cycle; the instruction sampled on edge k is committed and flagged by out_valid after edge k.
// Backpressure: none; one instruction is executed on every cycle that in_valid is high, with no stall.
module sp_core #(
  parameter int MEM_DEPTH = 4096,
  parameter int MEM_AW    = 12
) (
  input  logic     clk,
  input  logic     rst_n,
  sp_core_if.slave bus
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'd0,
    OP_ANDI  = 6'd1,
    OP_ORI   = 6'd2,
    OP_ADDI  = 6'd3,
    OP_SUBI  = 6'd4,
    OP_LW    = 6'd5,
    OP_SW    = 6'd6,
    OP_BEQ   = 6'd7,
    OP_BNE   = 6'd8,
    OP_LUI   = 6'd9
  } op_e;

  localparam logic [5:0] FN_AND = 6'd0;
  localparam logic [5:0] FN_OR  = 6'd1;
  localparam logic [5:0] FN_ADD = 6'd2;
  localparam logic [5:0] FN_SUB = 6'd3;
  localparam logic [5:0] FN_SLT = 6'd4;
  localparam logic [5:0] FN_SLL = 6'd5;

  // Architectural state; r and mem keep these names so external checkers can reach them
  logic [31:0] r   [0:31];
  logic [31:0] mem [0:MEM_DEPTH-1];
  logic [31:0] r_pc;
  logic        r_out_valid;

  // Instruction fields
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_func;
  logic [15:0] w_imm;

  assign w_op    = bus.inst[31:26];
  assign w_rs    = bus.inst[25:21];
  assign w_rt    = bus.inst[20:16];
  assign w_rd    = bus.inst[15:11];
  assign w_shamt = bus.inst[10:6];
  assign w_func  = bus.inst[5:0];
  assign w_imm   = bus.inst[15:0];

  // Operands come straight from committed state, so back-to-back dependencies need no forwarding
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic [31:0] w_imm_sext;
  logic [31:0] w_imm_zext;

  assign w_rs_val   = r[w_rs];
  assign w_rt_val   = r[w_rt];
  assign w_imm_sext = {{16{w_imm[15]}}, w_imm};
  assign w_imm_zext = {16'h0000, w_imm};

  // Effective address wraps: only the low MEM_AW bits of the 32-bit sum select a word
  logic [MEM_AW-1:0] w_mem_addr;
  logic [31:0]       w_mem_rdat;
  logic              w_mem_we;

  assign w_mem_addr = MEM_AW'(w_rs_val + w_imm_sext);
  assign w_mem_rdat = mem[w_mem_addr];
  assign w_mem_we   = bus.in_valid && (w_op == OP_SW);

  // R-type ALU; every func code from 6 upward decodes as nor
  logic [31:0] w_alu_r;
  always_comb begin
    w_alu_r = '0;
    case (w_func)
      FN_AND:  w_alu_r = w_rs_val & w_rt_val;
      FN_OR:   w_alu_r = w_rs_val | w_rt_val;
      FN_ADD:  w_alu_r = w_rs_val + w_rt_val;
      FN_SUB:  w_alu_r = w_rs_val - w_rt_val;
      FN_SLT:  w_alu_r = {31'b0, ($signed(w_rs_val) < $signed(w_rt_val))};
      FN_SLL:  w_alu_r = w_rs_val << w_shamt;
      default: w_alu_r = ~(w_rs_val | w_rt_val);
    endcase
  end

  // Writeback select: destination index, data and enable per opcode; unknown opcodes are no-ops
  logic        w_wr_en;
  logic [4:0]  w_wr_idx;
  logic [31:0] w_wr_dat;
  always_comb begin
    w_wr_en  = 1'b0;
    w_wr_idx = w_rt;
    w_wr_dat = '0;
    case (w_op)
      OP_RTYPE: begin
        w_wr_en  = 1'b1;
        w_wr_idx = w_rd;
        w_wr_dat = w_alu_r;
      end
      OP_ANDI: begin
        w_wr_en  = 1'b1;
        w_wr_dat = w_rs_val & w_imm_zext;
      end
      OP_ORI: begin
        w_wr_en  = 1'b1;
        w_wr_dat = w_rs_val | w_imm_zext;
      end
      OP_ADDI: begin
        w_wr_en  = 1'b1;
        w_wr_dat = w_rs_val + w_imm_sext;
      end
      OP_SUBI: begin
        w_wr_en  = 1'b1;
        w_wr_dat = w_rs_val - w_imm_sext;
      end
      OP_LW: begin
        w_wr_en  = 1'b1;
        w_wr_dat = w_mem_rdat;
      end
      OP_LUI: begin
        w_wr_en  = 1'b1;
        w_wr_dat = {w_imm, 16'h0000};
      end
      default: begin
        w_wr_en = 1'b0;
      end
    endcase
  end

  // Next fetch address: sequential, or PC-relative word offset when a branch is taken
  logic        w_br_taken;
  logic [31:0] w_pc_seq;
  logic [31:0] w_pc_next;
  always_comb begin
    w_pc_seq   = r_pc + 32'd4;
    w_br_taken = 1'b0;
    case (w_op)
      OP_BEQ:  w_br_taken = (w_rs_val == w_rt_val);
      OP_BNE:  w_br_taken = (w_rs_val != w_rt_val);
      default: w_br_taken = 1'b0;
    endcase
    w_pc_next = w_br_taken ? (w_pc_seq + (w_imm_sext << 2)) : w_pc_seq;
  end

  // Register file: cleared by reset, one write port committed with the instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r[i] <= '0;
      end
    end else if (bus.in_valid && w_wr_en) begin
      r[w_wr_idx] <= w_wr_dat;
    end
  end

  // Data memory keeps its contents across reset; a store caught by reset is dropped
  always_ff @(posedge clk) begin
    if (rst_n && w_mem_we) begin
      mem[w_mem_addr] <= w_rt_val;
    end
  end

  // PC advances only on executed instructions; out_valid is in_valid delayed by one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_pc <= w_pc_next;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.inst_addr = r_pc;

endmodule

// File: tb/tb_sp_core.sv
// tb_sp_core: directed and randomized checks of sp_core against an instruction-level reference model.
// Latency: expects retire one edge after each accepted instruction.
// Backpressure: none; instructions are presented whenever the bench chooses.
module tb_sp_core;
  localparam int MEM_DEPTH = 4096;
  localparam int MEM_AW    = 12;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  bit   clk_en = 1'b0;

  sp_core_if bus ();

  sp_core #(.MEM_DEPTH(MEM_DEPTH), .MEM_AW(MEM_AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Gated clock so reset can be pulsed with the clock held low
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural state only
  logic [31:0] m_r [32];
  logic [31:0] m_pc;
  logic        m_vld;
  logic [31:0] m_mem [int];
  int          m_wr_q [$];
  int          m_sw_addr;

  function automatic logic [31:0] enc_r(int func, int rs, int rt, int rd, int sh);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(func)};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_r[i] = '0;
    m_pc  = '0;
    m_vld = 1'b0;
  endfunction

  // Executes one instruction on the model, reading operands before any write
  function automatic void model_exec(input logic [31:0] ins);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] a, b, se, ze, res, npc;
    int          addr;
    op  = ins[31:26];
    rs  = ins[25:21];
    rt  = ins[20:16];
    rd  = ins[15:11];
    sh  = ins[10:6];
    fn  = ins[5:0];
    a   = m_r[rs];
    b   = m_r[rt];
    se  = {{16{ins[15]}}, ins[15:0]};
    ze  = {16'h0000, ins[15:0]};
    addr = int'((a + se) % MEM_DEPTH);
    npc = m_pc + 32'd4;
    case (op)
      6'd0: begin
        case (fn)
          6'd0:    res = a & b;
          6'd1:    res = a | b;
          6'd2:    res = a + b;
          6'd3:    res = a - b;
          6'd4:    res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'd5:    res = a << sh;
          default: res = ~(a | b);
        endcase
        m_r[rd] = res;
      end
      6'd1: m_r[rt] = a & ze;
      6'd2: m_r[rt] = a | ze;
      6'd3: m_r[rt] = a + se;
      6'd4: m_r[rt] = a - se;
      6'd5: m_r[rt] = m_mem[addr];
      6'd6: begin
        m_mem[addr] = b;
        m_wr_q.push_back(addr);
        m_sw_addr = addr;
      end
      6'd7: if (a == b) npc = m_pc + 32'd4 + (se << 2);
      6'd8: if (a != b) npc = m_pc + 32'd4 + (se << 2);
      6'd9: m_r[rt] = {ins[15:0], 16'h0000};
      default: ;
    endcase
    m_pc = npc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".out_valid"}, {31'b0, bus.out_valid}, {31'b0, m_vld});
    chk({ctx, ".inst_addr"}, bus.inst_addr, m_pc);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("%s.r%0d", ctx, i), dut.r[i], m_r[i]);
    end
  endtask

  // One clock: present (v, ins), advance the model, check after the falling edge
  task automatic step(input logic v, input logic [31:0] ins, input string ctx);
    bus.in_valid = v;
    bus.inst     = v ? ins : 32'hxxxx_xxxx;
    if (v) model_exec(ins);
    m_vld = v;
    @(posedge clk);
    @(negedge clk);
    check_all(ctx);
  endtask

  // Reset pulse with the clock stopped low; checks asynchronous clearing
  task automatic hold_reset(input string ctx);
    clk_en       = 1'b0;
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    model_reset();
    chk({ctx, ".pc0"}, bus.inst_addr, 32'h0);
    chk({ctx, ".vld0"}, {31'b0, bus.out_valid}, 32'h0);
    check_all(ctx);
    rst_n = 1'b1;
    #2 clk_en = 1'b1;
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] ins;
    logic [31:0] pc_save;
    int          sel, rs, rt, rd, imm, k;

    bus.in_valid = 1'b0;
    bus.inst     = '0;
    m_sw_addr    = 0;
    model_reset();

    hold_reset("reset");

    // ALU chain
    step(1'b1, enc_i(3, 0, 1, 16'hFFFD), "addi");
    chk("first_out_valid", {31'b0, bus.out_valid}, 32'd1);
    step(1'b1, enc_i(2, 0, 2, 16'hFFFF), "ori");
    step(1'b1, enc_r(4, 1, 2, 3, 0), "slt");
    step(1'b1, enc_r(5, 2, 0, 4, 4), "sll");
    step(1'b1, enc_r(6, 1, 2, 5, 0), "nor");
    step(1'b1, enc_i(9, 0, 6, 16'h8001), "lui");
    chk("alu_r1", dut.r[1], 32'hFFFFFFFD);
    chk("alu_r2", dut.r[2], 32'h0000FFFF);
    chk("alu_r3", dut.r[3], 32'h00000001);
    chk("alu_r4", dut.r[4], 32'h000FFFF0);
    chk("alu_r5", dut.r[5], 32'h00000000);
    chk("alu_r6", dut.r[6], 32'h80010000);
    chk("alu_pc", bus.inst_addr, 32'd24);

    // Memory: store/load, then wrap of a negative offset to the top word
    step(1'b1, enc_i(3, 0, 1, 100), "addi100");
    step(1'b1, enc_i(6, 1, 1, 4), "sw104");
    chk("mem104", dut.mem[104], 32'd100);
    step(1'b1, enc_i(5, 0, 7, 104), "lw104");
    chk("lw_r7", dut.r[7], 32'd100);
    rnd = $urandom;
    step(1'b1, enc_i(9, 0, 9, int'(rnd[31:16])), "lui_r9");
    step(1'b1, enc_i(2, 9, 9, int'(rnd[15:0])), "ori_r9");
    step(1'b1, enc_i(6, 0, 9, 16'hFFFF), "sw_wrap");
    chk("mem4095", dut.mem[4095], rnd);
    step(1'b1, enc_i(5, 0, 8, 16'hFFFF), "lw_wrap");
    chk("lw_wrap_r8", dut.r[8], rnd);

    // Gap: two idle cycles leave state alone and drop out_valid for exactly two cycles
    pc_save = m_pc;
    step(1'b0, '0, "gap1");
    chk("gap1_vld", {31'b0, bus.out_valid}, 32'd0);
    step(1'b0, '0, "gap2");
    chk("gap2_pc", bus.inst_addr, pc_save);
    step(1'b1, enc_i(3, 0, 10, 7), "after_gap");
    chk("after_gap_vld", {31'b0, bus.out_valid}, 32'd1);

    // Mid-run reset with a store in flight
    step(1'b1, enc_i(3, 0, 1, 16'h0055), "mr1");
    step(1'b1, enc_i(6, 0, 1, 200), "mr2");
    step(1'b1, enc_i(3, 0, 2, 16'h0077), "mr3");
    step(1'b1, enc_i(3, 0, 3, 1), "mr4");
    step(1'b1, enc_r(2, 1, 2, 4, 0), "mr5");
    bus.in_valid = 1'b1;
    bus.inst     = enc_i(6, 0, 2, 200);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midreset");
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_mem200", dut.mem[200], 32'h55);
    chk("midreset_mem104", dut.mem[104], 32'd100);
    check_all("midreset_rel");

    // Branches
    hold_reset("br_reset");
    step(1'b1, enc_i(3, 0, 1, 5), "br_r1");
    step(1'b1, enc_i(3, 0, 2, 5), "br_r2");
    step(1'b1, enc_i(7, 1, 2, 3), "beq");
    chk("beq_taken", bus.inst_addr, 32'd24);
    step(1'b1, enc_i(8, 1, 2, 16'hFFFE), "bne_nt");
    chk("bne_not_taken", bus.inst_addr, 32'd28);
    step(1'b1, enc_i(3, 0, 3, 1), "br_r3");
    step(1'b1, enc_i(63, 0, 0, 0), "nop1");
    step(1'b1, enc_i(63, 0, 0, 0), "nop2");
    chk("pc40", bus.inst_addr, 32'd40);
    step(1'b1, enc_i(8, 1, 3, 16'hFFFD), "bne_back");
    chk("bne_backward", bus.inst_addr, 32'd32);

    // Randomized program against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        step(1'b0, '0, "rnd_idle");
      end else begin
        sel = $urandom_range(0, 11);
        rs  = $urandom_range(0, 7);
        rt  = $urandom_range(0, 7);
        rd  = $urandom_range(0, 7);
        imm = $urandom_range(0, 65535);
        case (sel)
          0: begin
            k = $urandom_range(0, 7);
            if (k == 7) k = $urandom_range(6, 63);
            ins = enc_r(k, rs, rt, rd, $urandom_range(0, 31));
          end
          1, 2, 3, 4, 6, 9: ins = enc_i(sel, rs, rt, imm);
          5: begin
            if (m_wr_q.size() > 0) begin
              k   = m_wr_q[$urandom_range(0, m_wr_q.size() - 1)];
              ins = enc_i(5, rs, rt, k - int'(m_r[rs]));
            end else begin
              ins = enc_i(63, rs, rt, imm);
            end
          end
          7, 8: ins = enc_i(sel, rs, rt, $urandom_range(0, 15) - 8);
          default: ins = enc_i($urandom_range(10, 63), rs, rt, imm);
        endcase
        step(1'b1, ins, "rnd");
        if (ins[31:26] == 6'd6) begin
          chk("rnd_mem", dut.mem[m_sw_addr], m_mem[m_sw_addr]);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
